// File: rtl/particle_stream_fifo_if.sv
// Valid/ready stream bundle for the particle record FIFO: producer side,
// consumer side, and occupancy status.
interface particle_stream_fifo_if #(
  parameter int unsigned WIDTH = 114,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             almost_full;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count, almost_full
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count, almost_full
  );
endinterface

// File: rtl/particle_stream_fifo.sv
// First-word-fall-through elastic buffer for particle records with a registered
// head stage, occupancy count and almost-full flag.
module particle_stream_fifo #(
  parameter int unsigned WIDTH       = 114,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ALMOST_FULL = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  particle_stream_fifo_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    mem_cnt;
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_valid_q, head_valid_d;
  logic             in_ready_q, almost_full_q;
  logic             push, pop, head_free, mem_rd, mem_wr;

  // The head register counts toward occupancy; the array holds everything behind it.
  always_comb begin
    push         = bus.in_valid & in_ready_q & ~flush;
    pop          = head_valid_q & bus.out_ready & ~flush;
    mem_cnt      = count_q - CW'(head_valid_q);
    head_free    = ~head_valid_q | pop;
    mem_rd       = head_free & (mem_cnt != '0);
    mem_wr       = push & ~(head_free & (mem_cnt == '0));
    head_d       = head_q;
    head_valid_d = head_valid_q;
    wp_d         = wp_q + AW'(mem_wr);
    rp_d         = rp_q + AW'(mem_rd);
    count_d      = count_q;

    // Refill the head from the array first; an empty array lets a push land directly.
    if (head_free) begin
      if (mem_rd) begin
        head_d       = mem[rp_q];
        head_valid_d = 1'b1;
      end else if (push) begin
        head_d       = bus.in_data;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      count_d      = '0;
      head_valid_d = 1'b0;
      wp_d         = '0;
      rp_d         = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q          <= '0;
      rp_q          <= '0;
      count_q       <= '0;
      head_q        <= '0;
      head_valid_q  <= 1'b0;
      in_ready_q    <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      count_q       <= count_d;
      head_q        <= head_d;
      head_valid_q  <= head_valid_d;
      in_ready_q    <= (count_d != CW'(DEPTH));
      almost_full_q <= (count_d >= CW'(ALMOST_FULL));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_wr) begin
      mem[wp_q] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(bus.in_valid && in_ready_q && (count_q == CW'(DEPTH))))
        else $error("particle_stream_fifo: push while full");
      assert (!(mem_rd && (mem_cnt == '0)))
        else $error("particle_stream_fifo: read from empty storage");
    end
  end

  assign bus.in_ready    = in_ready_q & ~flush;
  assign bus.out_data    = head_q;
  assign bus.out_valid   = head_valid_q;
  assign bus.count       = count_q;
  assign bus.almost_full = almost_full_q;
endmodule

// File: tb/tb_particle_stream_fifo.sv
// Directed and randomized bench for particle_stream_fifo against a queue-based
// reference model of the buffer contents.
module tb_particle_stream_fifo;
  localparam int unsigned W  = 114;
  localparam int unsigned D  = 16;
  localparam int unsigned AF = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  particle_stream_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  particle_stream_fifo #(.WIDTH(W), .DEPTH(D), .ALMOST_FULL(AF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [W-1:0] q[$];
  logic         ready_en = 1'b0;
  logic         known    = 1'b0;
  logic         last_push = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_rec();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  // Drive one cycle, compare outputs with the model, then advance the model.
  task automatic step(input logic v, input logic [W-1:0] d, input logic ordy,
                      input logic fl, input logic rn);
    logic do_push, do_pop;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    rst_n         = rn;
    #1;
    if (known) begin
      check("count",       128'(bus.count),       128'(q.size()));
      check("out_valid",   128'(bus.out_valid),   128'(q.size() != 0));
      check("in_ready",    128'(bus.in_ready),    128'(ready_en && (q.size() != D) && !fl));
      check("almost_full", 128'(bus.almost_full), 128'(q.size() >= AF));
      if (q.size() != 0) check("out_data", 128'(bus.out_data), 128'(q[0]));
    end
    do_push = 1'b0;
    do_pop  = 1'b0;
    if (!rn) begin
      q.delete();
      ready_en = 1'b0;
      known    = 1'b1;
    end else if (fl) begin
      q.delete();
      ready_en = 1'b1;
    end else begin
      do_pop  = ordy && (q.size() != 0);
      do_push = v && ready_en && (q.size() != D);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
      ready_en = 1'b1;
    end
    last_push = do_push;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int sent;
    int guard;
    logic [W-1:0] rec;

    // Reset held three cycles with in_valid asserted.
    for (int i = 0; i < 3; i++) step(1'b1, rnd_rec(), 1'b0, 1'b0, 1'b0);
    check("rst_out_data", 128'(bus.out_data), 128'(0));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Latency and order.
    step(1'b1, W'(1), 1'b0, 1'b0, 1'b1);
    step(1'b1, W'(2), 1'b0, 1'b0, 1'b1);
    step(1'b1, W'(3), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("drain_empty", 128'(bus.count), 128'(0));

    // Fill to full, then push+pop while full.
    for (int i = 0; i < 17; i++) step(1'b1, rnd_rec(), 1'b0, 1'b0, 1'b1);
    check("full_count", 128'(bus.count), 128'(16));
    step(1'b1, rnd_rec(), 1'b1, 1'b0, 1'b1);
    check("full_pushpop", 128'(bus.count), 128'(15));
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Wrap with random stalls, including all-ones and all-zeros records.
    sent  = 0;
    guard = 0;
    while (sent < 40 && guard < 2000) begin
      if (sent == 7)       rec = '1;
      else if (sent == 20) rec = '0;
      else                 rec = rnd_rec();
      step(1'($urandom_range(0, 3) != 0), rec, 1'($urandom_range(0, 2) != 0), 1'b0, 1'b1);
      if (last_push) sent++;
      guard++;
    end
    check("wrap_sent", 128'(sent), 128'(40));
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      step(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      guard++;
    end
    check("wrap_drained", 128'(bus.count), 128'(0));

    // Simultaneous push and pop at count 5.
    for (int i = 0; i < 5; i++) step(1'b1, rnd_rec(), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, rnd_rec(), 1'b1, 1'b0, 1'b1);
    check("steady_count", 128'(bus.count), 128'(5));
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Flush mid-stream at count 9.
    for (int i = 0; i < 9; i++) step(1'b1, rnd_rec(), 1'b0, 1'b0, 1'b1);
    check("pre_flush", 128'(bus.count), 128'(9));
    step(1'b1, rnd_rec(), 1'b1, 1'b1, 1'b1);
    check("flush_count", 128'(bus.count), 128'(0));
    check("flush_valid", 128'(bus.out_valid), 128'(0));
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Reset mid-stream at count 9.
    for (int i = 0; i < 9; i++) step(1'b1, rnd_rec(), 1'b0, 1'b0, 1'b1);
    check("pre_reset", 128'(bus.count), 128'(9));
    step(1'b1, rnd_rec(), 1'b1, 1'b0, 1'b0);
    check("reset_count", 128'(bus.count), 128'(0));
    check("reset_valid", 128'(bus.out_valid), 128'(0));
    step(1'b1, W'(5), 1'b0, 1'b0, 1'b1);
    step(1'b1, W'(6), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
